// File: rtl/heart_hit_manager.sv
// heart_hit_manager: tracks hits, lives and post-hit invincibility for the heart sprite.
// Consumes the raw collision level and produces the invincible level for the movement logic,
// the remaining lives, a game-over flag, a one-cycle hit pulse and the sprite enable.
// Optional blinking of the sprite while invincible is built when HEART_BLINK_EN is defined;
// without it heartVisible is constant 1 and the blink counter does not exist.
module heart_hit_manager #(
  parameter int INITIAL_LIVES     = 3,
  parameter int LIVES_WIDTH       = 3,
  parameter int INVINCIBLE_FRAMES = 60,
  parameter int BLINK_PERIOD      = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   collision,
  input  logic                   restart,
  input  logic                   godMode,
  output logic                   invincible,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic                   gameOver,
  output logic                   hitPulse,
  output logic                   heartVisible
);

  localparam int FRAME_W = $clog2(INVINCIBLE_FRAMES + 1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT  = LIVES_WIDTH'(INITIAL_LIVES);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE   = LIVES_WIDTH'(1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ZERO  = LIVES_WIDTH'(0);
  localparam logic [FRAME_W-1:0]     FRAMES_FULL = FRAME_W'(INVINCIBLE_FRAMES);
  localparam logic [FRAME_W-1:0]     FRAME_ONE   = FRAME_W'(1);
  localparam logic [FRAME_W-1:0]     FRAME_ZERO  = FRAME_W'(0);

`ifdef HEART_BLINK_EN
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_ZERO = BLINK_W'(0);
  logic [BLINK_W-1:0] blink_cnt_r;
`endif

  typedef enum logic [1:0] {
    ST_ALIVE      = 2'd0,
    ST_INVINCIBLE = 2'd1,
    ST_DEAD       = 2'd2
  } state_t;

  state_t                 state_r;
  logic [FRAME_W-1:0]     frame_cnt_r;
  logic [LIVES_WIDTH-1:0] lives_r;
  logic                   game_over_r;
  logic                   hit_pulse_r;
  logic                   heart_visible_r;

  // Hit/lives/invincibility state machine; restart is a synchronous clear with top priority
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r         <= ST_ALIVE;
      lives_r         <= LIVES_INIT;
      frame_cnt_r     <= FRAME_ZERO;
      game_over_r     <= 1'b0;
      hit_pulse_r     <= 1'b0;
      heart_visible_r <= 1'b1;
`ifdef HEART_BLINK_EN
      blink_cnt_r     <= BLINK_ZERO;
`endif
    end else if (restart) begin
      state_r         <= ST_ALIVE;
      lives_r         <= LIVES_INIT;
      frame_cnt_r     <= FRAME_ZERO;
      game_over_r     <= 1'b0;
      hit_pulse_r     <= 1'b0;
      heart_visible_r <= 1'b1;
`ifdef HEART_BLINK_EN
      blink_cnt_r     <= BLINK_ZERO;
`endif
    end else begin
      hit_pulse_r <= 1'b0;
      case (state_r)
        ST_ALIVE: begin
          // Level-sensitive hit: a held collision is accepted again as soon as ALIVE is re-entered
          if (collision && !godMode) begin
            hit_pulse_r <= 1'b1;
            if (lives_r == LIVES_ONE) begin
              state_r     <= ST_DEAD;
              lives_r     <= LIVES_ZERO;
              game_over_r <= 1'b1;
            end else begin
              state_r     <= ST_INVINCIBLE;
              lives_r     <= lives_r - LIVES_ONE;
              frame_cnt_r <= FRAMES_FULL;
`ifdef HEART_BLINK_EN
              blink_cnt_r     <= BLINK_ZERO;
              heart_visible_r <= 1'b0;
`endif
            end
          end else begin
            state_r <= ST_ALIVE;
          end
        end
        ST_INVINCIBLE: begin
          // Collisions are ignored here; only frame pulses advance the window
          if (startOfFrame) begin
            if (frame_cnt_r == FRAME_ONE) begin
              state_r         <= ST_ALIVE;
              frame_cnt_r     <= FRAME_ZERO;
              heart_visible_r <= 1'b1;
`ifdef HEART_BLINK_EN
              blink_cnt_r     <= BLINK_ZERO;
`endif
            end else begin
              frame_cnt_r <= frame_cnt_r - FRAME_ONE;
`ifdef HEART_BLINK_EN
              if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r     <= BLINK_ZERO;
                heart_visible_r <= ~heart_visible_r;
              end else begin
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
              end
`endif
            end
          end else begin
            state_r <= ST_INVINCIBLE;
          end
        end
        ST_DEAD: begin
          lives_r     <= LIVES_ZERO;
          game_over_r <= 1'b1;
        end
        default: begin
          state_r         <= ST_ALIVE;
          lives_r         <= LIVES_INIT;
          frame_cnt_r     <= FRAME_ZERO;
          game_over_r     <= 1'b0;
          heart_visible_r <= 1'b1;
        end
      endcase
    end
  end

  assign invincible   = (state_r == ST_INVINCIBLE) | godMode;
  assign lives        = lives_r;
  assign gameOver     = game_over_r;
  assign hitPulse     = hit_pulse_r;
  assign heartVisible = heart_visible_r;

endmodule

// File: tb/tb_heart_hit_manager.sv
// Self-checking bench for heart_hit_manager: directed scenarios followed by randomized stimulus,
// all compared each cycle against a lives/frames-remaining reference model.
module tb_heart_hit_manager;

  localparam int LW        = 3;
  localparam int INIT      = 3;
  localparam int FRAMES    = 60;
  localparam int BLINK     = 4;
  localparam int FRAME_LEN = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          startOfFrame;
  logic          collision;
  logic          restart;
  logic          godMode;
  logic          invincible;
  logic [LW-1:0] lives;
  logic          gameOver;
  logic          hitPulse;
  logic          heartVisible;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: lives left and invincibility frames left (0 = not invincible)
  int m_lives;
  int m_inv_left;
  bit m_pulse;

  always #5 clk = ~clk;

  heart_hit_manager #(
    .INITIAL_LIVES(INIT), .LIVES_WIDTH(LW), .INVINCIBLE_FRAMES(FRAMES), .BLINK_PERIOD(BLINK)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
    .restart(restart), .godMode(godMode), .invincible(invincible), .lives(lives),
    .gameOver(gameOver), .hitPulse(hitPulse), .heartVisible(heartVisible)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_lives    = INIT;
    m_inv_left = 0;
    m_pulse    = 1'b0;
  endfunction

  // Sprite is hidden for the first BLINK frames of the window, shown for the next BLINK, and so on
  function automatic int exp_visible();
`ifdef HEART_BLINK_EN
    if (m_inv_left > 0) return ((FRAMES - m_inv_left) / BLINK) % 2;
`endif
    return 1;
  endfunction

  // Apply the game rules to the inputs present at this clock edge
  function automatic void model_edge();
    if (restart) begin
      model_reset();
    end else begin
      m_pulse = 1'b0;
      if (m_lives == 0) begin
        // dead: nothing but restart/reset changes anything
      end else if (m_inv_left > 0) begin
        if (startOfFrame) m_inv_left--;
      end else if (collision && !godMode) begin
        m_pulse = 1'b1;
        m_lives--;
        if (m_lives > 0) m_inv_left = FRAMES;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, ".lives"},      32'(lives),        32'(m_lives));
    check_val({tag, ".gameOver"},   32'(gameOver),     32'(m_lives == 0));
    check_val({tag, ".hitPulse"},   32'(hitPulse),     32'(m_pulse));
    check_val({tag, ".invincible"}, 32'(invincible),   32'((m_inv_left > 0) || godMode));
    check_val({tag, ".visible"},    32'(heartVisible), 32'(exp_visible()));
  endtask

  task automatic step(input string tag, input bit coll, input bit god, input bit rst_p);
    collision    = coll;
    godMode      = god;
    restart      = rst_p;
    startOfFrame = ((cyc % FRAME_LEN) == (FRAME_LEN - 1));
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all(tag);
  endtask

  int frames;
  int pulses;
  bit r_god;

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    collision    = 1'b0;
    restart      = 1'b0;
    godMode      = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    resetN = 1'b1;

    // 1: idle ten frames
    for (int i = 0; i < 10 * FRAME_LEN; i++) step("idle", 1'b0, 1'b0, 1'b0);

    // 2: single-cycle hit, then count frames of invincibility
    step("hit1", 1'b1, 1'b0, 1'b0);
    check_val("hit1_lives", 32'(lives), 32'd2);
    frames = 0;
    for (int i = 0; i < 400; i++) begin
      step("inv_window", 1'b0, 1'b0, 1'b0);
      if (startOfFrame) frames++;
      if (!invincible) break;
    end
    check_val("inv_frames", 32'(frames), 32'd60);

    // 3: collision held until death
    step("restart", 1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 200 * FRAME_LEN; i++) begin
      step("hold", 1'b1, 1'b0, 1'b0);
      if (hitPulse) pulses++;
    end
    check_val("hold_pulses", 32'(pulses), 32'd3);
    check_val("hold_dead",   32'(gameOver), 32'd1);

    // 4: restart together with collision while dead
    step("restart_coll", 1'b1, 1'b0, 1'b1);
    check_val("restart_lives", 32'(lives), 32'd3);
    check_val("restart_pulse", 32'(hitPulse), 32'd0);

    // 5: god mode with collision held for 100 frames
    pulses = 0;
    for (int i = 0; i < 100 * FRAME_LEN; i++) begin
      step("god", 1'b1, 1'b1, 1'b0);
      if (hitPulse) pulses++;
    end
    check_val("god_pulses", 32'(pulses), 32'd0);
    check_val("god_lives",  32'(lives),  32'd3);

    // 6: hit, run into the window, then asynchronous reset without a clock edge
    step("hit6", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) step("win6", 1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    check_val("async_inv", 32'(invincible), 32'd0);
    #5;
    resetN = 1'b1;

    // randomized traffic
    r_god = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) r_god = ~r_god;
      step("rand", ($urandom_range(0, 7) == 0), r_god, ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
